// File: rtl/canvas_pkg.sv
// Canvas geometry, pixel type and streamer state encoding, shared by canvas_editor,
// color_mapper and canvas_streamer.
package canvas_pkg;

  localparam int CANVAS_DIM    = 28;
  localparam int CANVAS_DW     = 16;
  localparam int CANVAS_PIXELS = CANVAS_DIM * CANVAS_DIM;
  localparam int CANVAS_IDXW   = 10;
  localparam int CANVAS_CW     = 5;

  typedef logic [CANVAS_DW-1:0]   pixel_t;
  typedef logic [CANVAS_IDXW-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } stream_state_e;

endpackage

// File: rtl/canvas_streamer_if.sv
// Valid/ready pixel stream from the canvas streamer into the network input layer.
interface canvas_streamer_if #(
  parameter int DW   = canvas_pkg::CANVAS_DW,
  parameter int IDXW = canvas_pkg::CANVAS_IDXW
);

  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [IDXW-1:0] out_index;
  logic            out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/canvas_raster_counter.sv
// Row-major raster position: row/col with wrap, linear index and last-pixel flag.
// clr wins over adv; advancing past the final pixel wraps back to (0,0).
module canvas_raster_counter
  import canvas_pkg::*;
#(
  parameter int DIM  = CANVAS_DIM,
  parameter int IDXW = CANVAS_IDXW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 adv,
  output logic [CANVAS_CW-1:0] row,
  output logic [CANVAS_CW-1:0] col,
  output logic [IDXW-1:0]      index,
  output logic                 last
);

  localparam logic [CANVAS_CW-1:0] POS_MAX = CANVAS_CW'(DIM - 1);
  localparam logic [CANVAS_CW-1:0] POS_ONE = CANVAS_CW'(1);

  logic [CANVAS_CW-1:0] row_q, row_d;
  logic [CANVAS_CW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (adv) begin
      if (col_q == POS_MAX) begin
        col_d = '0;
        row_d = (row_q == POS_MAX) ? '0 : row_q + POS_ONE;
      end else begin
        col_d = col_q + POS_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row   = row_q;
  assign col   = col_q;
  assign last  = (row_q == POS_MAX) && (col_q == POS_MAX);
  assign index = IDXW'(row_q) * IDXW'(DIM) + IDXW'(col_q);

endmodule

// File: rtl/canvas_streamer.sv
// Streams the DIM x DIM canvas row-major over a valid/ready interface on each compute request.
// Defining CANVAS_STREAM_BINARIZE_EN maps every non-zero pixel to ONE_VAL and zero pixels to 0.
module canvas_streamer
  import canvas_pkg::*;
#(
  parameter int            DIM     = CANVAS_DIM,
  parameter int            DW      = CANVAS_DW,
  parameter int            IDXW    = CANVAS_IDXW,
  parameter logic [DW-1:0] ONE_VAL = DW'(16'h0100)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [DW-1:0]     canvas [DIM][DIM],
  canvas_streamer_if.master out_if,
  output logic              busy,
  output logic              done
);

`ifdef CANVAS_STREAM_BINARIZE_EN
  localparam bit BINARIZE = 1'b1;
`else
  localparam bit BINARIZE = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_LOAD   = LOAD;
  localparam logic [1:0] ST_STREAM = STREAM;
  localparam logic [1:0] ST_DONE   = DONE;

  logic [1:0]      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [IDXW-1:0] out_index_q, out_index_d;

  logic                 cnt_clr, cnt_adv, cnt_last;
  logic [CANVAS_CW-1:0] cnt_row, cnt_col;
  logic [IDXW-1:0]      cnt_index;
  logic [DW-1:0]        pix_raw, pix_word;
  logic                 xfer, load_px;

  // The counter always points at the next pixel to be loaded into the output register.
  canvas_raster_counter #(
    .DIM  (DIM),
    .IDXW (IDXW)
  ) u_cnt (
    .clk   (Clk),
    .rst   (Reset),
    .clr   (cnt_clr),
    .adv   (cnt_adv),
    .row   (cnt_row),
    .col   (cnt_col),
    .index (cnt_index),
    .last  (cnt_last)
  );

  assign pix_raw = canvas[cnt_row][cnt_col];
  assign xfer    = out_valid_q && out_if.out_ready;

  always_comb begin
    pix_word = pix_raw;
    if (BINARIZE) begin
      pix_word = (pix_raw != '0) ? ONE_VAL : '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    cnt_clr     = 1'b0;
    cnt_adv     = 1'b0;
    load_px     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_LOAD;
          cnt_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        load_px = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (xfer) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            cnt_clr     = 1'b1;
            state_d     = ST_DONE;
          end else begin
            load_px = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides any transfer happening on the same edge.
    if (Abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      cnt_clr     = 1'b1;
      load_px     = 1'b0;
    end

    if (load_px) begin
      out_data_d  = pix_word;
      out_index_d = cnt_index;
      out_last_d  = cnt_last;
      out_valid_d = 1'b1;
      cnt_adv     = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_index = out_index_q;
  assign out_if.out_last  = out_last_q;

  assign busy = (state_q == ST_LOAD) || (state_q == ST_STREAM);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_canvas_streamer.sv
// Bench for canvas_streamer: random canvases and random out_ready checked against a
// row-major reference model (word k carries pixel [k/DIM][k%DIM]).
module tb_canvas_streamer;
  import canvas_pkg::*;

  localparam int N = CANVAS_PIXELS;

  logic   Clk   = 1'b0;
  logic   Reset = 1'b1;
  logic   Start = 1'b0;
  logic   Abort = 1'b0;
  logic   busy;
  logic   done;
  pixel_t canvas [CANVAS_DIM][CANVAS_DIM];

  int n_checks = 0;
  int n_fail   = 0;

  pixel_t got_data [$];
  int     got_idx  [$];
  bit     got_last [$];
  int     rise_cyc [$];
  int     done_cyc [$];
  int     stall_bad;
  int     last_xfer;
  bit     done_busy;

  canvas_streamer_if #(.DW(CANVAS_DW), .IDXW(CANVAS_IDXW)) out_if ();

  canvas_streamer dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Abort  (Abort),
    .canvas (canvas),
    .out_if (out_if),
    .busy   (busy),
    .done   (done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  function automatic pixel_t model_word(input int k);
    pixel_t p;
    p = canvas[5'(k / CANVAS_DIM)][5'(k % CANVAS_DIM)];
`ifdef CANVAS_STREAM_BINARIZE_EN
    return (p != '0) ? 16'h0100 : 16'h0000;
`else
    return p;
`endif
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < CANVAS_DIM; r++)
      for (int c = 0; c < CANVAS_DIM; c++)
        canvas[5'(r)][5'(c)] = pixel_t'(r * CANVAS_DIM + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < CANVAS_DIM; r++)
      for (int c = 0; c < CANVAS_DIM; c++)
        canvas[5'(r)][5'(c)] = ($urandom_range(3) == 0) ? pixel_t'(0) : pixel_t'($urandom);
  endtask

  // Issues Start and plays the downstream sink; Start stays high for multi-stream runs.
  // Cycle numbers count edges after the one preceding the Start drive.
  task automatic drive_stream(input int ready_pct, input int n_streams, input int limit);
    bit     stalled, prev_valid;
    pixel_t sd;
    idx_t   si;
    logic   sl;
    got_data.delete(); got_idx.delete(); got_last.delete();
    rise_cyc.delete(); done_cyc.delete();
    stall_bad = 0; last_xfer = -1; done_busy = 0;
    stalled = 0; prev_valid = 0; sd = '0; si = '0; sl = 1'b0;
    @(posedge Clk); #1;
    Start = 1'b1;
    out_if.out_ready = 1'b0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(posedge Clk); #1;
      if (stalled && (out_if.out_valid !== 1'b1 || out_if.out_data !== sd ||
                      out_if.out_index !== si || out_if.out_last !== sl))
        stall_bad++;
      if (done === 1'b1) begin
        done_cyc.push_back(cyc);
        if (busy !== 1'b0) done_busy = 1;
      end
      if (out_if.out_valid === 1'b1 && !prev_valid) rise_cyc.push_back(cyc);
      prev_valid = (out_if.out_valid === 1'b1);
      Start = (n_streams > 1) && (done_cyc.size() < n_streams);
      out_if.out_ready = (int'($urandom_range(99)) < ready_pct);
      if (out_if.out_valid === 1'b1 && out_if.out_ready) begin
        got_data.push_back(out_if.out_data);
        got_idx.push_back(int'(out_if.out_index));
        got_last.push_back(out_if.out_last === 1'b1);
        last_xfer = cyc;
      end
      stalled = (out_if.out_valid === 1'b1) && !out_if.out_ready;
      sd = out_if.out_data; si = out_if.out_index; sl = out_if.out_last;
      if (done_cyc.size() >= n_streams && cyc >= done_cyc[done_cyc.size()-1] + 2) break;
    end
    Start = 1'b0;
    out_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; out_if.out_ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++;
    if ({out_if.out_valid, out_if.out_last, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got valid/last/busy/done %b, expected 0000",
               {out_if.out_valid, out_if.out_last, busy, done});
    end
    n_checks++;
    if (out_if.out_data !== '0 || out_if.out_index !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got data %h index %0d, expected 0 0", out_if.out_data, out_if.out_index);
    end
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++;
    if ({out_if.out_valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: got valid/busy/done %b, expected 000", {out_if.out_valid, busy, done});
    end
  endtask

  task automatic test_full_stream();
    int nlast, last_pos, dc, rc;
    fill_ramp();
    drive_stream(100, 1, 1000);
    n_checks++;
    if (got_data.size() != N) begin
      n_fail++; $display("FAIL full_count: got %0d words, expected %0d", got_data.size(), N);
    end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++;
      if (got_idx[k] != k || got_data[k] !== model_word(k)) begin
        n_fail++;
        $display("FAIL full_word: got idx %0d data %h, expected idx %0d data %h",
                 got_idx[k], got_data[k], k, model_word(k));
        break;
      end
    end
    nlast = 0; last_pos = -1;
    for (int k = 0; k < got_last.size(); k++)
      if (got_last[k]) begin nlast++; last_pos = k; end
    n_checks++;
    if (nlast != 1 || last_pos != N - 1) begin
      n_fail++; $display("FAIL full_last: got %0d lasts at %0d, expected 1 at %0d", nlast, last_pos, N - 1);
    end
    rc = (rise_cyc.size() > 0) ? rise_cyc[0] : -1;
    n_checks++;
    if (rc != 2) begin
      n_fail++; $display("FAIL full_latency: got first valid at cycle %0d, expected 2", rc);
    end
    dc = (done_cyc.size() == 1) ? done_cyc[0] : -1;
    n_checks++;
    if (dc != last_xfer + 1) begin
      n_fail++; $display("FAIL full_done_pulse: got done at %0d (%0d pulses), expected single at %0d",
                         dc, done_cyc.size(), last_xfer + 1);
    end
    n_checks++;
    if (dc + 1 != 787) begin
      n_fail++; $display("FAIL full_total_cycles: got %0d, expected 787", dc + 1);
    end
    n_checks++;
    if (done_busy) begin
      n_fail++; $display("FAIL full_busy_in_done: got busy 1 during done, expected 0");
    end
  endtask

  task automatic test_random_ready();
    fill_random();
    drive_stream(50, 1, 4000);
    n_checks++;
    if (got_data.size() != N) begin
      n_fail++; $display("FAIL rand_count: got %0d words, expected %0d", got_data.size(), N);
    end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++;
      if (got_idx[k] != k || got_data[k] !== model_word(k)) begin
        n_fail++;
        $display("FAIL rand_word: got idx %0d data %h, expected idx %0d data %h",
                 got_idx[k], got_data[k], k, model_word(k));
        break;
      end
    end
    n_checks++;
    if (stall_bad != 0) begin
      n_fail++; $display("FAIL rand_stall_hold: got %0d unstable stall cycles, expected 0", stall_bad);
    end
    n_checks++;
    if (done_cyc.size() != 1) begin
      n_fail++; $display("FAIL rand_done: got %0d done pulses, expected 1", done_cyc.size());
    end
  endtask

  task automatic test_row_wrap();
    fill_random();
    canvas[0][27] = 16'hAAAA;
    canvas[1][0]  = 16'h5555;
    drive_stream(70, 1, 3000);
    n_checks++;
    if (got_data.size() < 29) begin
      n_fail++; $display("FAIL wrap_count: got %0d words, expected at least 29", got_data.size());
    end else begin
      n_checks++;
      if (got_idx[27] != 27 || got_data[27] !== model_word(27)) begin
        n_fail++; $display("FAIL wrap_27: got idx %0d data %h, expected idx 27 data %h",
                           got_idx[27], got_data[27], model_word(27));
      end
      n_checks++;
      if (got_idx[28] != 28 || got_data[28] !== model_word(28)) begin
        n_fail++; $display("FAIL wrap_28: got idx %0d data %h, expected idx 28 data %h",
                           got_idx[28], got_data[28], model_word(28));
      end
    end
  endtask

  task automatic test_abort();
    bit found;
    int seen;
    fill_ramp();
    found = 0; seen = 0;
    @(posedge Clk); #1;
    Start = 1'b1; out_if.out_ready = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
      if (out_if.out_valid === 1'b1 && out_if.out_index === idx_t'(400)) begin
        found = 1; break;
      end
    end
    Abort = 1'b1;
    @(posedge Clk); #1;
    Abort = 1'b0;
    out_if.out_ready = 1'b0;
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL abort_reach: got index 400 valid 0, expected 1");
    end
    n_checks++;
    if ({out_if.out_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL abort_stop: got valid/busy %b, expected 00", {out_if.out_valid, busy});
    end
    repeat (8) begin
      @(posedge Clk); #1;
      if (done === 1'b1 || out_if.out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL abort_quiet: got %0d cycles with done/valid, expected 0", seen);
    end
    drive_stream(100, 1, 1000);
    n_checks++;
    if (got_data.size() != N || got_idx[0] != 0 || rise_cyc.size() == 0 || rise_cyc[0] != 2) begin
      n_fail++; $display("FAIL abort_restart: got %0d words from index %0d, expected %0d from 0",
                         got_data.size(), (got_idx.size() > 0) ? got_idx[0] : -1, N);
    end
  endtask

  task automatic test_reset_mid_stream();
    bit found;
    int seen;
    fill_ramp();
    found = 0; seen = 0;
    @(posedge Clk); #1;
    Start = 1'b1; out_if.out_ready = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
      if (out_if.out_valid === 1'b1 && out_if.out_index === idx_t'(100)) begin
        found = 1; break;
      end
    end
    Reset = 1'b1;
    #1;
    n_checks++;
    if (!found || {out_if.out_valid, out_if.out_last, busy, done} !== 4'b0000 ||
        out_if.out_data !== '0 || out_if.out_index !== '0) begin
      n_fail++; $display("FAIL reset_mid_async: got valid/last/busy/done %b data %h index %0d, expected 0000 0 0",
                         {out_if.out_valid, out_if.out_last, busy, done}, out_if.out_data, out_if.out_index);
    end
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    repeat (6) begin
      @(posedge Clk); #1;
      if (done === 1'b1 || out_if.out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    out_if.out_ready = 1'b0;
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_mid_idle: got %0d active cycles after release, expected 0", seen);
    end
  endtask

  task automatic test_binarize();
    for (int r = 0; r < CANVAS_DIM; r++)
      for (int c = 0; c < CANVAS_DIM; c++)
        canvas[5'(r)][5'(c)] = '0;
    canvas[0][0] = 16'h0000;
    canvas[0][1] = 16'h0001;
    canvas[0][2] = 16'hFFFF;
    drive_stream(100, 1, 1000);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got_data.size() <= k || got_data[k] !== model_word(k)) begin
        n_fail++; $display("FAIL bin_word: got %h at index %0d, expected %h",
                           (got_data.size() > k) ? got_data[k] : pixel_t'('x), k, model_word(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    drive_stream(100, 2, 2000);
    n_checks++;
    if (done_cyc.size() != 2 || done_cyc[1] - done_cyc[0] != 787) begin
      n_fail++; $display("FAIL b2b_done: got %0d pulses spaced %0d, expected 2 spaced 787", done_cyc.size(),
                         (done_cyc.size() == 2) ? done_cyc[1] - done_cyc[0] : -1);
    end
    n_checks++;
    if (rise_cyc.size() != 2 || done_cyc.size() < 1 || rise_cyc[1] != done_cyc[0] + 3) begin
      n_fail++; $display("FAIL b2b_gap: got second stream at %0d, expected %0d",
                         (rise_cyc.size() > 1) ? rise_cyc[1] : -1,
                         (done_cyc.size() > 0) ? done_cyc[0] + 3 : -1);
    end
    n_checks++;
    if (got_data.size() != 2 * N) begin
      n_fail++; $display("FAIL b2b_count: got %0d words, expected %0d", got_data.size(), 2 * N);
    end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++;
      if (got_idx[k] != k % N || got_data[k] !== model_word(k % N)) begin
        n_fail++; $display("FAIL b2b_word: got idx %0d data %h, expected idx %0d data %h",
                           got_idx[k], got_data[k], k % N, model_word(k % N));
        break;
      end
    end
  endtask

  initial begin
    out_if.out_ready = 1'b0;
    test_reset();
    test_full_stream();
    test_random_ready();
    test_row_wrap();
    test_abort();
    test_reset_mid_stream();
    test_binarize();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
